// File: rtl/noc_link_tx_if.sv
// Link transmitter bus bundle: buffer read side plus credit-based link side.
// The master modport is the transmitter; the slave modport is its environment
// (output buffer FIFO and downstream router input).
interface noc_link_tx_if #(
    parameter int unsigned FLIT_W = 16
);
    logic [FLIT_W-1:0] buf_data;
    logic              buf_empty;
    logic              buf_read;
    logic              link_valid;
    logic [FLIT_W-1:0] link_flit;
    logic              link_credit;

    modport master (
        input  buf_data,
        input  buf_empty,
        input  link_credit,
        output buf_read,
        output link_valid,
        output link_flit
    );

    modport slave (
        output buf_data,
        output buf_empty,
        output link_credit,
        input  buf_read,
        input  link_valid,
        input  link_flit
    );
endinterface

// File: rtl/noc_link_tx.sv
// Credit-based link transmitter. Pops flits from the output buffer only while
// the downstream buffer has a free slot, forwards them onto the link two cycles
// after the pop, checks packet framing on the outgoing stream and counts packets.
module noc_link_tx #(
    parameter int unsigned FLIT_W  = 16,
    parameter int unsigned CREDITS = 4,
    parameter int unsigned CNT_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    noc_link_tx_if.master      lnk,
    output logic [CNT_W-1:0]   credits,
    output logic [7:0]         pkts_sent,
    output logic               frame_err,
    output logic               credit_err,
    output logic               busy
);

    localparam logic [CNT_W-1:0] CreditsFull = CNT_W'(CREDITS);
    localparam logic [CNT_W-1:0] CntOne      = CNT_W'(1);

    // Flit type field: bit 0 marks a head, bit 1 marks a tail.
    localparam logic [1:0] TypeBody   = 2'b00;
    localparam logic [1:0] TypeHead   = 2'b01;
    localparam logic [1:0] TypeTail   = 2'b10;
    localparam logic [1:0] TypeSingle = 2'b11;

    typedef enum logic {StOut, StIn} frame_state_e;

    logic [CNT_W-1:0]  credits_q, credits_d;
    logic              credit_err_q, credit_err_d;
    logic              in_flight_q;
    logic              link_valid_q;
    logic [FLIT_W-1:0] link_flit_q;
    frame_state_e      state_q, state_d;
    logic [7:0]        pkts_q, pkts_d;
    logic              frame_err_q, frame_err_d;
    logic              issue;
    logic [1:0]        flit_type;

    // Held low during reset so no pop can slip out while the pipeline is cleared.
    assign issue     = rst && !lnk.buf_empty && (credits_q != '0);
    assign flit_type = link_flit_q[FLIT_W-1 -: 2];

    assign lnk.buf_read   = issue;
    assign lnk.link_valid = link_valid_q;
    assign lnk.link_flit  = link_flit_q;
    assign credits        = credits_q;
    assign pkts_sent      = pkts_q;
    assign frame_err      = frame_err_q;
    assign credit_err     = credit_err_q;
    assign busy           = link_valid_q || in_flight_q;

    // Credit accounting: reserve on issue, release on returned pulse, saturate at full.
    always_comb begin
        credits_d    = credits_q;
        credit_err_d = credit_err_q;
        case ({lnk.link_credit, issue})
            2'b10: begin
                if (credits_q == CreditsFull) begin
                    credit_err_d = 1'b1;
                end else begin
                    credits_d = credits_q + CntOne;
                end
            end
            2'b01:   credits_d = credits_q - CntOne;
            default: ;
        endcase
    end

    // Credit counter and overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credits_q    <= CreditsFull;
            credit_err_q <= 1'b0;
        end else begin
            credits_q    <= credits_d;
            credit_err_q <= credit_err_d;
        end
    end

    // Two-stage read pipeline: issue -> capture buffer data -> drive link.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_flight_q  <= 1'b0;
            link_valid_q <= 1'b0;
            link_flit_q  <= '0;
        end else begin
            in_flight_q  <= issue;
            link_valid_q <= in_flight_q;
            if (in_flight_q) begin
                link_flit_q <= lnk.buf_data;
            end
        end
    end

    // Framing next state: errors only report; an unexpected head restarts the packet.
    always_comb begin
        state_d     = state_q;
        pkts_d      = pkts_q;
        frame_err_d = frame_err_q;
        if (link_valid_q) begin
            unique case (state_q)
                StOut: begin
                    unique case (flit_type)
                        TypeHead:   state_d = StIn;
                        TypeSingle: pkts_d  = pkts_q + 8'd1;
                        default:    frame_err_d = 1'b1;
                    endcase
                end
                StIn: begin
                    unique case (flit_type)
                        TypeBody: ;
                        TypeTail: begin
                            state_d = StOut;
                            pkts_d  = pkts_q + 8'd1;
                        end
                        TypeHead: frame_err_d = 1'b1;
                        TypeSingle: begin
                            frame_err_d = 1'b1;
                            state_d     = StOut;
                            pkts_d      = pkts_q + 8'd1;
                        end
                        default: ;
                    endcase
                end
                default: state_d = StOut;
            endcase
        end
    end

    // Framing state, packet counter and sticky framing error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StOut;
            pkts_q      <= 8'd0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pkts_q      <= pkts_d;
            frame_err_q <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_noc_link_tx.sv
// Bench for noc_link_tx: a directed vector table, hand-written corner sequences and
// a randomized phase, all continuously checked against a packet-level reference model.
module tb_noc_link_tx;

    localparam int CREDITS = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] credits;
    logic [7:0] pkts_sent;
    logic       frame_err;
    logic       credit_err;
    logic       busy;

    noc_link_tx_if #(.FLIT_W(16)) lnk ();

    noc_link_tx #(.FLIT_W(16), .CREDITS(4), .CNT_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .lnk        (lnk),
        .credits    (credits),
        .pkts_sent  (pkts_sent),
        .frame_err  (frame_err),
        .credit_err (credit_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- buffer emulation ----------------
    logic [15:0] mem [4096];
    int          wr_ptr = 0;
    int          rd_ptr = 0;

    assign lnk.buf_empty = (wr_ptr == rd_ptr);

    initial begin
        lnk.buf_data = '0;
        forever begin
            @(posedge clk);
            if (rst && lnk.buf_read) begin
                lnk.buf_data <= mem[rd_ptr];
                rd_ptr       <= rd_ptr + 1;
            end
        end
    end

    task automatic push(input logic [15:0] f);
        mem[wr_ptr] = f;
        wr_ptr++;
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        logic [15:0] flit;
    } pend_t;

    pend_t      pend[$];
    int         cyc = 0;
    int         m_rd = 0;
    int         m_credits = CREDITS;
    logic [7:0] m_pkts = 8'd0;
    bit         m_ferr = 1'b0;
    bit         m_cerr = 1'b0;
    bit         m_in_pkt = 1'b0;
    bit         m_last_read = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            if (!rst) begin
                pend.delete();
                m_credits   = CREDITS;
                m_pkts      = 8'd0;
                m_ferr      = 1'b0;
                m_cerr      = 1'b0;
                m_in_pkt    = 1'b0;
                m_last_read = 1'b0;
            end else begin
                bit          rd;
                int          n;
                logic [15:0] f;
                bit          head;
                bit          tail;
                if (pend.size() != 0 && pend[0].due == cyc) begin
                    f    = pend.pop_front().flit;
                    head = f[14];
                    tail = f[15];
                    if (m_in_pkt ? head : !head) m_ferr = 1'b1;
                    if (tail && (head || m_in_pkt)) m_pkts = m_pkts + 8'd1;
                    m_in_pkt = (head || m_in_pkt) && !tail;
                end
                rd = (wr_ptr != m_rd) && (m_credits != 0);
                if (rd) begin
                    pend.push_back('{due: cyc + 2, flit: mem[m_rd]});
                    m_rd++;
                end
                n = m_credits + int'(lnk.link_credit) - int'(rd);
                if (n > CREDITS) begin
                    m_cerr = 1'b1;
                    n      = CREDITS;
                end
                m_credits   = n;
                m_last_read = rd;
            end
            cyc++;
        end
    end

    // Continuous comparison against the model, away from the active edge.
    initial begin
        forever begin
            bit exp_lv;
            @(negedge clk);
            if (!rst) begin
                check("rst_read", 32'(lnk.buf_read), 32'd0);
                check("rst_valid", 32'(lnk.link_valid), 32'd0);
                check("rst_credits", 32'(credits), 32'(CREDITS));
                check("rst_pkts", 32'(pkts_sent), 32'd0);
                check("rst_errs", {30'd0, frame_err, credit_err}, 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
            end else begin
                exp_lv = (pend.size() != 0) && (pend[0].due == cyc);
                check("m_read", 32'(lnk.buf_read), 32'((wr_ptr != m_rd) && (m_credits != 0)));
                check("m_valid", 32'(lnk.link_valid), 32'(exp_lv));
                if (exp_lv) check("m_flit", 32'(lnk.link_flit), 32'(pend[0].flit));
                check("m_credits", 32'(credits), 32'(m_credits));
                check("m_pkts", 32'(pkts_sent), 32'(m_pkts));
                check("m_frame_err", 32'(frame_err), 32'(m_ferr));
                check("m_credit_err", 32'(credit_err), 32'(m_cerr));
                check("m_busy", 32'(busy), 32'(exp_lv || m_last_read));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    typedef struct {
        bit          push;
        bit          credit;
        bit          br;
        logic [2:0]  cr;
        bit          lv;
        logic [15:0] flit;
        logic [7:0]  pk;
        bit          busy;
    } vec_t;

    vec_t        vecs [14];
    logic [15:0] burst [6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic give_credits(input int n);
        step();
        lnk.link_credit = 1'b1;
        repeat (n - 1) step();
        step();
        lnk.link_credit = 1'b0;
    endtask

    initial begin
        bit got;

        burst = '{16'h4001, 16'h0002, 16'h0003, 16'h8004, 16'hC005, 16'hC006};
        //             push crd br  cr    lv  flit      pk    busy
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 16'h0000, 8'd0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 16'h0000, 8'd0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 16'h0000, 8'd0, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 16'h4001, 8'd0, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 16'h0002, 8'd0, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 16'h0003, 8'd0, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 16'h8004, 8'd0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 8'd1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 16'h0000, 8'd1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 16'h0000, 8'd1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 16'h0000, 8'd1, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 16'hC005, 8'd1, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 16'hC006, 8'd2, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 8'd3, 1'b0};

        lnk.link_credit = 1'b0;
        rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        @(negedge clk);
        check("reset_flit", 32'(lnk.link_flit), 32'h0);

        // Idle, 6-flit burst with no returns, then two credit pulses.
        for (int i = 0; i < 14; i++) begin
            step();
            if (vecs[i].push) for (int j = 0; j < 6; j++) push(burst[j]);
            lnk.link_credit = vecs[i].credit;
            @(negedge clk);
            check($sformatf("vec%0d_read", i), 32'(lnk.buf_read), 32'(vecs[i].br));
            check($sformatf("vec%0d_credits", i), 32'(credits), 32'(vecs[i].cr));
            check($sformatf("vec%0d_valid", i), 32'(lnk.link_valid), 32'(vecs[i].lv));
            if (vecs[i].lv) check($sformatf("vec%0d_flit", i), 32'(lnk.link_flit),
                                  32'(vecs[i].flit));
            check($sformatf("vec%0d_pkts", i), 32'(pkts_sent), 32'(vecs[i].pk));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
        end
        step();
        lnk.link_credit = 1'b0;

        // Return and issue on the same edges leave the count unchanged.
        give_credits(2);
        for (int i = 0; i < 5; i++) push(16'hC000 | 16'(i));
        lnk.link_credit = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("simul_credits", 32'(credits), 32'd2);
            check("simul_read", 32'(lnk.buf_read), 32'd1);
            step();
        end
        lnk.link_credit = 1'b0;
        @(negedge clk);
        check("simul_credits_after", 32'(credits), 32'd2);
        repeat (6) step();
        check("simul_pkts", 32'(pkts_sent), 32'd8);

        // Body flit outside a packet: forwarded unchanged, flagged, not counted.
        give_credits(4);
        push(16'h1234);
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (lnk.link_valid) begin
                got = 1'b1;
                break;
            end
        end
        check("frame_wait_valid", 32'(got), 32'd1);
        check("frame_flit", 32'(lnk.link_flit), 32'h1234);
        @(negedge clk);
        check("frame_err_set", 32'(frame_err), 32'd1);
        check("frame_pkts_same", 32'(pkts_sent), 32'd8);

        // Head, head, tail: the second head restarts the packet, one packet counted.
        step();
        push(16'h4011);
        push(16'h4012);
        push(16'h8013);
        repeat (8) step();
        check("head_head_tail_pkts", 32'(pkts_sent), 32'd9);
        check("frame_err_sticky", 32'(frame_err), 32'd1);

        // Overflow: refill to full, then one extra return.
        give_credits(4);
        @(negedge clk);
        check("refill_credits", 32'(credits), 32'd4);
        check("no_credit_err", 32'(credit_err), 32'd0);
        step();
        lnk.link_credit = 1'b1;
        step();
        lnk.link_credit = 1'b0;
        @(negedge clk);
        check("credit_err_set", 32'(credit_err), 32'd1);
        check("overflow_credits", 32'(credits), 32'd4);

        // Reset between a pop and its capture: the flit must never appear.
        step();
        push(16'hC0AA);
        @(negedge clk);
        check("midrst_issue", 32'(lnk.buf_read), 32'd1);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_valid", 32'(lnk.link_valid), 32'd0);
        check("midrst_credits", 32'(credits), 32'd4);
        check("midrst_frame_err", 32'(frame_err), 32'd0);
        check("midrst_credit_err", 32'(credit_err), 32'd0);
        step();
        step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("postrst_valid", 32'(lnk.link_valid), 32'd0);
            step();
        end

        // Random traffic, credit returns and occasional resets.
        for (int i = 0; i < 2000; i++) begin
            step();
            rst = 1'b1;
            if ($urandom_range(0, 1) == 1) push(16'($urandom));
            lnk.link_credit = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 199) == 0) rst = 1'b0;
        end
        step();
        rst = 1'b1;
        lnk.link_credit = 1'b0;
        repeat (5) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/noc_link_tx.md
# noc_link_tx

Credit-based link transmitter for a router output port. It drains flits from the output-side buffer FIFO and drives them onto the inter-router link. It sends only when the downstream input buffer has a free slot, tracked by a credit counter. It also checks packet framing on the transmitted stream and counts completed packets.

## Interface
Parameters:
- FLIT_W, 16, flit width; bits [FLIT_W-1:FLIT_W-2] are the flit type (00 body, 01 head, 10 tail, 11 single-flit head+tail)
- CREDITS, 4, downstream buffer depth = initial credit count
- CNT_W, 3, credit counter width; must hold CREDITS

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- buf_data  in  FLIT_W  buffer read data, valid the cycle after buf_read
- buf_empty  in  1  buffer holds no flit
- buf_read  out  1  pop strobe, one flit per cycle asserted
- link_valid  out  1  link_flit valid this cycle
- link_flit  out  FLIT_W  flit on link (registered)
- link_credit  in  1  one-cycle pulse = one downstream slot freed
- credits  out  CNT_W  current credit count
- pkts_sent  out  8  completed packets sent, wraps 255->0
- frame_err  out  1  sticky framing error
- credit_err  out  1  sticky credit overflow
- busy  out  1  a read is in flight or link_valid is high

## Operation
- Issue (stage 0): buf_read = !buf_empty && credits != 0. This is combinational and may assert every cycle (back-to-back).
- A credit is reserved at issue: on that clock edge, credits decrements.
- Capture (stage 1): the cycle after issue, buf_data is valid. At the end of that cycle, link_flit <= buf_data and link_valid <= 1. Otherwise link_valid <= 0.
- Credit arithmetic, per edge: credits += link_credit - buf_read.
  - Simultaneous return and issue: count unchanged.
  - Return while credits == CREDITS and no issue: count holds at CREDITS, credit_err <= 1.
  - Underflow is impossible, because issue requires credits != 0.
- Framing FSM, evaluated on each flit with link_valid = 1:
  - OUT state:
    - head -> IN.
    - single -> OUT, pkts_sent++.
    - body or tail -> frame_err <= 1, stay OUT.
  - IN state:
    - body -> IN.
    - tail -> OUT, pkts_sent++.
    - head or single -> frame_err <= 1. Treat it as a new packet start: head -> IN; single -> OUT and pkts_sent++.
- Flits are forwarded unchanged even when erroneous. The error flags only report.
- busy = link_valid || (a read was issued last cycle).

## Timing
- Reset (rst = 0, asynchronous) forces:
  - link_valid = 0, link_flit = 0
  - credits = CREDITS, pkts_sent = 0
  - frame_err = 0, credit_err = 0
  - FSM = OUT, in-flight capture flag = 0
- buf_read is 0 while rst = 0. A read in flight at reset is discarded and never appears on the link.
- Latency: buf_read high in cycle t -> link_valid high in cycle t+2, carrying the flit popped at t.
- Sustained throughput is 1 flit/cycle while credits are available and the buffer is non-empty.
- With zero credits, buf_read stays low. The first link_credit pulse at edge e enables issue in the cycle after e.
- credits output reflects the post-edge value; it is registered and has no combinational path from link_credit.
- frame_err and credit_err stay set until reset.

## Test plan
- Reset then idle:
  - Stimulus: buf_empty = 1.
  - Required: credits = 4, link_valid = 0, buf_read = 0, pkts_sent = 0, busy = 0.
- Burst with no credit return:
  - Stimulus: 6 flits queued (head, body, body, tail, single, single).
  - Required: exactly 4 buf_read pulses on consecutive cycles; link_valid is high for cycles t+2..t+5; credits steps 4->0; pkts_sent = 1; no further read.
- Credit return resumes sending:
  - Stimulus: from the end of the previous test, pulse link_credit twice.
  - Required: the two single flits are sent; pkts_sent = 3; credits returns to 0.
- Simultaneous credit return and issue:
  - Stimulus: credits = 2, with link_credit and buf_read both high for 3 cycles.
  - Required: credits stays 2 throughout.
- Framing errors:
  - Stimulus: body flit 0x1234 while in OUT.
  - Required: frame_err = 1, flit forwarded as 0x1234, pkts_sent unchanged.
  - Stimulus: head, head, tail.
  - Required: pkts_sent += 1.
- Credit overflow and reset mid-burst:
  - Stimulus: link_credit pulse while credits = 4.
  - Required: credit_err = 1, credits = 4.
  - Stimulus: assert rst between a buf_read and its capture.
  - Required: link_valid stays 0, credits = 4, both error flags clear.
